// File: rtl/gray_arb_pkg.sv
// -----------------------------------------------------------------------------
// gray_arb_pkg
// Shared definitions for the Gray-code step arbiter:
//   - state_t        : arbiter FSM state encoding (IDLE / RUN / DONE)
//   - GRAY_0..GRAY_7 : the 3-bit Gray sequence in stepping order
//   - CNT_W          : width of the remaining-step counter (holds 1..8)
//   - gray_succ()    : next code in the Gray sequence
//   - steps_to_count : maps a 3-bit step request to a counter load (0 -> 8)
// -----------------------------------------------------------------------------
package gray_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A request of 0 means a full cycle of 8 steps, so the counter needs 4 bits.
    localparam int CNT_W = 4;

    // Gray sequence in stepping order: 0,1,3,2,6,7,5,4.
    localparam logic [2:0] GRAY_0 = 3'b000;
    localparam logic [2:0] GRAY_1 = 3'b001;
    localparam logic [2:0] GRAY_2 = 3'b011;
    localparam logic [2:0] GRAY_3 = 3'b010;
    localparam logic [2:0] GRAY_4 = 3'b110;
    localparam logic [2:0] GRAY_5 = 3'b111;
    localparam logic [2:0] GRAY_6 = 3'b101;
    localparam logic [2:0] GRAY_7 = 3'b100;

    function automatic logic [2:0] gray_succ(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            GRAY_0:  nxt = GRAY_1;
            GRAY_1:  nxt = GRAY_2;
            GRAY_2:  nxt = GRAY_3;
            GRAY_3:  nxt = GRAY_4;
            GRAY_4:  nxt = GRAY_5;
            GRAY_5:  nxt = GRAY_6;
            GRAY_6:  nxt = GRAY_7;
            default: nxt = GRAY_0;
        endcase
        return nxt;
    endfunction

    function automatic logic [CNT_W-1:0] steps_to_count(input logic [2:0] steps);
        return (steps == 3'd0) ? CNT_W'(8) : CNT_W'(steps);
    endfunction

endpackage

// File: rtl/gray3_core.sv
// -----------------------------------------------------------------------------
// gray3_core
// 3-bit Gray-code stepper. Advances one code per clock while En is high.
// Ports:
//   Clk   in   clock, all state on posedge
//   Reset in   synchronous active-high reset, Code -> 0
//   En    in   step enable
//   Code  out  current Gray code
//   Wrap  out  high on the cycle whose edge moves Code from 4 back to 0
// -----------------------------------------------------------------------------
module gray3_core
    import gray_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       En,
    output logic [2:0] Code,
    output logic       Wrap
);

    assign Wrap = En && (Code == GRAY_7);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Code <= GRAY_0;
        end else if (En) begin
            Code <= gray_succ(Code);
        end
    end

endmodule

// File: rtl/gray_step_arb.sv
// -----------------------------------------------------------------------------
// gray_step_arb
// Round-robin arbiter granting two requesters bursts of steps on a shared
// 3-bit Gray stepper. FSM: IDLE -> RUN (N steps) -> DONE (1 cycle) -> IDLE.
// Ports:
//   Clk      in   clock, all state on posedge
//   Reset    in   synchronous active-high reset
//   Req[1:0] in   request per requester
//   Steps0   in   step count for requester 0 (0 = 8), sampled at grant
//   Steps1   in   step count for requester 1 (0 = 8), sampled at grant
//   Gnt[1:0] out  one-hot grant, 00 when idle
//   Busy     out  high in RUN and DONE
//   Done     out  one-cycle pulse at burst completion
//   Code     out  current Gray code
//   Overflow out  sticky, set on the first 4 -> 0 wrap
// Build option:
//   GRAY_ARB_ABORT_EN : dropping the granted Req bit during RUN aborts the
//                       burst (Code frozen, back to IDLE, no Done pulse).
// -----------------------------------------------------------------------------
module gray_step_arb
    import gray_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Req,
    input  logic [2:0] Steps0,
    input  logic [2:0] Steps1,
    output logic [1:0] Gnt,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] Code,
    output logic       Overflow
);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;   // index of the requester served last
    logic             overflow_q;
    logic             step_en;
    logic             wrap;
    logic             pick;             // requester chosen by arbitration
    logic             abort;

    gray3_core u_core (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (step_en),
        .Code  (Code),
        .Wrap  (wrap)
    );

    // On a tie the requester not served last wins.
    always_comb begin
        pick = 1'b0;
        case (Req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

`ifdef GRAY_ARB_ABORT_EN
    // gnt_q is one-hot in RUN, so masking Req with it isolates the granted bit.
    assign abort = (state_q == ST_RUN) && ((Req & gnt_q) == 2'b00);
`else
    assign abort = 1'b0;
`endif

    // NOTE: every output of this block gets a default first; without that a
    // path that skips an assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        step_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Req != 2'b00) begin
                    state_d = ST_RUN;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    cnt_d   = steps_to_count(pick ? Steps1 : Steps0);
                    last_d  = pick;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Pointer already moved at grant, so the aborted burst
                    // counts as served.
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end else begin
                    step_en = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Always pass through IDLE, so no regrant on release.
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 2'b00;
            cnt_q      <= '0;
            last_q     <= 1'b1;   // "last served = 1" makes requester 0 win the first tie
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            overflow_q <= overflow_q | wrap;
        end
    end

    assign Gnt      = gnt_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_gray_step_arb.sv
// -----------------------------------------------------------------------------
// tb_gray_step_arb
// Self-checking bench for gray_step_arb. A table of bursts is replayed through
// a scoreboard (expected result pushed at drive, popped at Done), followed by
// hand-written sequences for alternation, 8-step wrap, mid-burst reset and
// the Req-drop case (behaviour depends on GRAY_ARB_ABORT_EN).
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gray_step_arb;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic [1:0] Req    = 2'b00;
    logic [2:0] Steps0 = 3'd0;
    logic [2:0] Steps1 = 3'd0;
    logic [1:0] Gnt;
    logic       Busy;
    logic       Done;
    logic [2:0] Code;
    logic       Overflow;

    gray_step_arb dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Steps0   (Steps0),
        .Steps1   (Steps1),
        .Gnt      (Gnt),
        .Busy     (Busy),
        .Done     (Done),
        .Code     (Code),
        .Overflow (Overflow)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] req;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] exp_gnt;
        int         exp_steps;
        logic [2:0] exp_code;
        logic       exp_ovf;
    } burst_t;

    logic [2:0] gray_seq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    logic [1:0] alt_gnt  [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    logic       alt_done [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    int     gidx      = 0;      // position of expected Code in gray_seq
    logic   ovf_model = 1'b0;
    burst_t sb [$];
    burst_t tbl [6];
    int     n_checks  = 0;
    int     n_pass    = 0;
    logic   done_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Req   = 2'b00;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_gnt",  32'(Gnt),      32'h0);
        check("rst_busy", 32'(Busy),     32'h0);
        check("rst_done", 32'(Done),     32'h0);
        check("rst_code", 32'(Code),     32'h0);
        check("rst_ovf",  32'(Overflow), 32'h0);
        Reset     = 1'b0;
        gidx      = 0;
        ovf_model = 1'b0;
    endtask

    // Called on a falling edge with the DUT in IDLE; leaves it in IDLE.
    task automatic run_burst(input burst_t b);
        int     k;
        burst_t e;
        sb.push_back(b);
        Req    = b.req;
        Steps0 = b.s0;
        Steps1 = b.s1;
        @(posedge Clk);
        @(negedge Clk);
        check("grant", 32'(Gnt), 32'(b.exp_gnt));
        k = 0;
        while (Done !== 1'b1 && k < 12) begin
            check("run_code", 32'(Code),     32'(gray_seq[gidx]));
            check("run_ovf",  32'(Overflow), 32'(ovf_model));
            check("run_gnt",  32'(Gnt),      32'(b.exp_gnt));
            @(posedge Clk);
            if (gidx == 7) ovf_model = 1'b1;
            gidx = (gidx + 1) % 8;
            @(negedge Clk);
            k++;
        end
        e = sb.pop_front();
        check("done_seen",  32'(Done),     32'h1);
        check("run_cycles", 32'(k),        32'(e.exp_steps));
        check("done_code",  32'(Code),     32'(e.exp_code));
        check("done_gnt",   32'(Gnt),      32'(e.exp_gnt));
        check("done_ovf",   32'(Overflow), 32'(e.exp_ovf));
        check("done_busy",  32'(Busy),     32'h1);
        Req = 2'b00;
        @(posedge Clk);
        @(negedge Clk);
        check("idle_done", 32'(Done), 32'h0);
        check("idle_busy", 32'(Busy), 32'h0);
        check("idle_gnt",  32'(Gnt),  32'h0);
    endtask

    initial begin
        //          req    s0    s1    gnt   N  end   ovf
        tbl[0] = '{2'b01, 3'd3, 3'd0, 2'b01, 3, 3'd2, 1'b0};
        tbl[1] = '{2'b11, 3'd2, 3'd4, 2'b10, 4, 3'd4, 1'b0};
        tbl[2] = '{2'b11, 3'd1, 3'd1, 2'b01, 1, 3'd0, 1'b1};
        tbl[3] = '{2'b10, 3'd3, 3'd0, 2'b10, 8, 3'd0, 1'b1};
        tbl[4] = '{2'b01, 3'd5, 3'd0, 2'b01, 5, 3'd7, 1'b1};
        tbl[5] = '{2'b11, 3'd7, 3'd6, 2'b10, 6, 3'd2, 1'b1};

        do_reset();
        for (int i = 0; i < 6; i++) run_burst(tbl[i]);

        // Continuous tie with 1-step bursts: grants alternate, IDLE between.
        do_reset();
        Req    = 2'b11;
        Steps0 = 3'd1;
        Steps1 = 3'd1;
        for (int i = 0; i < 9; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check("alt_gnt",  32'(Gnt),  32'(alt_gnt[i]));
            check("alt_done", 32'(Done), 32'(alt_done[i]));
        end
        Req = 2'b00;

        // Full 8-step burst from Code 0: wraps on the final edge.
        do_reset();
        run_burst('{2'b10, 3'd5, 3'd0, 2'b10, 8, 3'd0, 1'b1});

        // Reset on the second RUN cycle of a 5-step burst.
        do_reset();
        Req    = 2'b01;
        Steps0 = 3'd5;
        @(posedge Clk);
        @(negedge Clk);
        check("mid_rst_grant", 32'(Gnt), 32'h1);
        @(posedge Clk);
        @(negedge Clk);
        check("mid_rst_code_before", 32'(Code), 32'h1);
        Reset = 1'b1;
        Req   = 2'b00;
        @(posedge Clk);
        @(negedge Clk);
        check("mid_rst_busy", 32'(Busy), 32'h0);
        check("mid_rst_gnt",  32'(Gnt),  32'h0);
        check("mid_rst_code", 32'(Code), 32'h0);
        check("mid_rst_done", 32'(Done), 32'h0);
        Reset     = 1'b0;
        done_seen = 1'b0;
        repeat (6) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done !== 1'b0) done_seen = 1'b1;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'h0);

        // Drop Req0 after 2 of 6 steps.
        do_reset();
        Req    = 2'b01;
        Steps0 = 3'd6;
        Steps1 = 3'd1;
        @(posedge Clk);
        @(negedge Clk);
        check("drop_grant", 32'(Gnt), 32'h1);
        @(posedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        check("drop_code_before", 32'(Code), 32'h3);
        Req = 2'b00;
`ifdef GRAY_ARB_ABORT_EN
        @(posedge Clk);
        @(negedge Clk);
        check("abort_busy", 32'(Busy), 32'h0);
        check("abort_code", 32'(Code), 32'h3);
        check("abort_gnt",  32'(Gnt),  32'h0);
        check("abort_done", 32'(Done), 32'h0);
        Req = 2'b11;
        @(posedge Clk);
        @(negedge Clk);
        check("abort_rr_gnt", 32'(Gnt), 32'h2);
        Req = 2'b00;
`else
        begin
            int k;
            k = 3;
            while (Done !== 1'b1 && k < 12) begin
                @(posedge Clk);
                @(negedge Clk);
                if (Done !== 1'b1) k++;
            end
            check("drop_done",   32'(Done), 32'h1);
            check("drop_cycles", 32'(k),    32'd6);
            check("drop_code",   32'(Code), 32'h5);
            check("drop_gnt",    32'(Gnt),  32'h1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_step_arb.md
GRAY_STEP_ARB -- requirements
Module: gray_step_arb

Interface
REQ-001 SHALL have port Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-003 SHALL have port Req  input  2  per-requester request for the shared 3-bit Gray stepper; bit i = requester i.
REQ-004 SHALL have port Steps0  input  3  step count for requester 0, sampled at grant; 0 means 8 steps.
REQ-005 SHALL have port Steps1  input  3  step count for requester 1, sampled at grant; 0 means 8 steps.
REQ-006 SHALL have port Gnt  output  2  one-hot grant, all-zero when idle.
REQ-007 SHALL have port Busy  output  1  high in RUN and DONE states.
REQ-008 SHALL have port Done  output  1  one-cycle pulse when the granted burst completes.
REQ-009 SHALL have port Code  output  3  current Gray code of the shared stepper.
REQ-010 SHALL have port Overflow  output  1  sticky flag, set on the first wrap 4->0, cleared only by Reset.

Function
REQ-011 Stepper sequence SHALL be 0,1,3,2,6,7,5,4,0,... with one step per cycle while stepping is enabled.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with any Req bit high SHALL move to RUN on the next edge, set Gnt to the chosen requester and load the 4-bit remaining count from its Steps input (0 loads 8).
REQ-014 Code SHALL NOT change in IDLE; the first step SHALL occur on the first edge in RUN.
REQ-015 In RUN, each edge SHALL advance Code by one step and decrement the remaining count; the edge on which the count goes 1->0 SHALL move the FSM to DONE.
REQ-016 A burst of N steps SHALL take exactly N cycles in RUN followed by one cycle in DONE.
REQ-017 DONE SHALL assert Done for exactly one cycle, hold Gnt, then return to IDLE.
REQ-018 Gnt SHALL stay stable from RUN entry through DONE.
REQ-019 Arbitration SHALL be round-robin: when both Req bits are high in IDLE, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-020 The last-served pointer SHALL update only at RUN entry.
REQ-021 A requester SHALL NOT be granted on the cycle it is released from DONE; IDLE always lasts at least one cycle.
REQ-022 Overflow SHALL set on the edge where Code moves 4->0 and SHALL stay set across subsequent bursts.

Reset
REQ-023 Reset SHALL force IDLE, Code=0, Gnt=00, Busy=0, Done=0, Overflow=0, remaining count=0 and the pointer to favour requester 0.
REQ-024 Reset SHALL take priority over every other event, including mid-RUN and in DONE; no Done pulse is produced for an interrupted burst.

Configuration
REQ-025 The macro GRAY_ARB_ABORT_EN SHALL control burst abort.
REQ-026 With GRAY_ARB_ABORT_EN defined, deasserting the granted Req bit in RUN SHALL freeze Code, go to IDLE on the next edge with no Done pulse, and count the aborted burst as served for round-robin.
REQ-027 Without GRAY_ARB_ABORT_EN, Req SHALL be ignored after grant and every burst runs to completion.

Structure
REQ-028 A shared package gray_arb_pkg SHALL hold the FSM state encodings, the Gray successor constants and the steps-zero-means-8 width constant.
REQ-029 The stepper SHALL be a sub-module, gray3_core, with ports Clk, Reset, En, Code and Wrap; the arbiter drives En only in RUN.

Verification
REQ-030 Reset, Req=01, Steps0=3 -> Gnt=01 next cycle; Code 1,3,2 over 3 RUN cycles; Done pulses once with Code=2; Overflow=0.
REQ-031 Req=11 held continuously, Steps0=Steps1=1 -> grants alternate 01,10,01; each grant separated by one IDLE cycle.
REQ-032 Req=10, Steps1=0 from Code=0 -> 8 steps ending at Code=0; Overflow=1 on the final edge; Done then pulses.
REQ-033 Reset asserted on the 2nd RUN cycle of a 5-step burst -> next cycle IDLE, Code=0, Gnt=00, and no Done pulse.
REQ-034 GRAY_ARB_ABORT_EN defined, Req0 dropped after 2 of 6 steps -> Code frozen at 3, IDLE, no Done; a following Req=11 grants 10. Without the macro -> all 6 steps complete and Done pulses.
